harvard_wait_memory: RTL and testbench
======================================

# harvard_wait_memory

Parametrised unified instruction/data memory for the multicycle CPU, replacing the zero-latency array model. It provides an instruction fetch port and a data load/store port, each with a request/ready handshake and a configurable number of wait states. Both ports share one word array, so stores are visible to fetches and a loader can write program text through the data port. Optional byte-lane write strobes are selected at compile time.

## Interface
- ADDRSIZE, 12, word address width; array depth MEMSIZE = 1<<ADDRSIZE words
- WIDTH, 32, word width in bits; must be a multiple of 8
- ACCESS_TIME, 2, wait states per access, legal range 0..15
- clk  input  1  clock, all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_req  input  1  fetch request
- i_addr  input  ADDRSIZE  fetch word address
- i_ready  output  1  one-cycle fetch completion pulse
- i_rdata  output  WIDTH  fetched word, valid while i_ready=1
- d_req  input  1  data request
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDRSIZE  data word address
- d_wdata  input  WIDTH  store data
- d_be  input  WIDTH/8  byte-lane write strobes, bit k covers bits 8k+7:8k (present only with MEM_BYTE_WRITE_EN)
- d_ready  output  1  one-cycle data completion pulse
- d_rdata  output  WIDTH  load result; on a store, the pre-write word

## Operation
- Each port has an independent FSM: IDLE, WAIT, RESP.
- IDLE: on a rising edge with req=1, the port accepts the request and latches address, plus we/wdata/be on the data port. It goes to RESP if ACCESS_TIME=0, else to WAIT with cnt=ACCESS_TIME-1.
- WAIT: cnt decrements each edge. At the edge where cnt=0, the port performs the access and goes to RESP.
- Access edge: rdata is registered from the array (read-first). A data-port store writes the enabled lanes at that same edge.
- RESP: ready=1 for exactly one cycle. On the next edge, req=1 is accepted as a new request (back-to-back); req=0 returns the port to IDLE.
- Inputs are sampled only on accepting edges. req, addr and data may change freely while the port is in WAIT or RESP.
- Collision: if a fetch access edge coincides with a store access edge to the same address, i_rdata returns the old word and the store completes normally.
- Array contents are not reset. Preload is done by $readmemh from the bench.
- rdata holds its last value outside RESP. Consumers must qualify it with ready.

## Timing
- Reset values: i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, both FSMs IDLE, counters 0.
- Latency: with acceptance at edge E0, the access happens at edge E(ACCESS_TIME) and ready is high during the cycle after that edge.
- Throughput: one transaction per ACCESS_TIME+1 cycles per port with req held high.
- The two ports never stall each other; both may be in WAIT at once.
- Reset asserted mid-transaction aborts it immediately. A store whose access edge has not yet occurred is dropped, and no ready pulse is produced.
- Release of reset is synchronised by the system. The first acceptance is possible at the first rising edge with rst_n=1.

## Configuration
- MEM_BYTE_WRITE_EN defined: d_be port exists; a store writes only lanes with d_be[k]=1, other lanes keep their old value. d_be=0 still completes with d_ready but leaves memory unchanged.
- MEM_BYTE_WRITE_EN undefined: no d_be port; every store writes the full word.

## Test plan
- ACCESS_TIME=2, mem[5]=32'h1234_5678, d_req load addr 5 at E0 -> d_ready high in the cycle after E2 only, d_rdata=32'h1234_5678.
- ACCESS_TIME=0, store 32'hDEAD_BEEF to addr 7 then load addr 7 back-to-back -> store response d_rdata=old mem[7]; load d_ready one cycle later with 32'hDEAD_BEEF; 2 transactions in 2 cycles.
- Simultaneous fetch addr 9 and store 32'hA5A5_A5A5 to addr 9 accepted on the same edge -> i_rdata=old mem[9]; a following fetch of addr 9 returns 32'hA5A5_A5A5.
- MEM_BYTE_WRITE_EN, mem[3]=32'h0000_0000, store 32'h1122_3344 with d_be=4'b0101 -> mem[3]=32'h0022_0044.
- Assert rst_n=0 one cycle after accepting a store to addr 2 (ACCESS_TIME=3) -> ready and rdata clear asynchronously, mem[2] unchanged, no d_ready after reset release.
- Hold i_req=1 for 12 cycles, ACCESS_TIME=2, incrementing i_addr each cycle -> exactly 4 i_ready pulses, each returning the address latched at its accepting edge.

Source files
------------

// File: rtl/harvard_wait_memory.sv
// Unified instruction/data memory with independent fetch and data ports, each with
// ACCESS_TIME wait states. Define MEM_BYTE_WRITE_EN to add byte-lane store strobes (d_be).

module hwm_port_ctrl #(
  parameter int ACCESS_TIME = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic accept,
  output logic access,
  output logic ready
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = (ACCESS_TIME == 0) ? 4'd0 : 4'(ACCESS_TIME - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE, RESP: begin
        state_nxt = IDLE;
        if (req) begin
          accept  = 1'b1;
          cnt_nxt = CNT_INIT;
          // Zero wait states: the accepting edge is also the access edge.
          if (ACCESS_TIME == 0) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == RESP);
endmodule

module harvard_wait_memory #(
  parameter int ADDRSIZE    = 12,
  parameter int WIDTH       = 32,
  parameter int ACCESS_TIME = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDRSIZE-1:0]   i_addr,
  output logic                  i_ready,
  output logic [WIDTH-1:0]      i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDRSIZE-1:0]   d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
`ifdef MEM_BYTE_WRITE_EN
  input  logic [WIDTH/8-1:0]    d_be,
`endif
  output logic                  d_ready,
  output logic [WIDTH-1:0]      d_rdata
);
  localparam int MEMSIZE = 1 << ADDRSIZE;
  localparam int NB      = WIDTH / 8;
  localparam bit ZW      = (ACCESS_TIME == 0);

  logic [WIDTH-1:0] mem [MEMSIZE];

  logic i_accept, i_access, d_accept, d_access;

  hwm_port_ctrl #(.ACCESS_TIME(ACCESS_TIME)) u_iport (
    .clk(clk), .rst_n(rst_n), .req(i_req),
    .accept(i_accept), .access(i_access), .ready(i_ready)
  );

  hwm_port_ctrl #(.ACCESS_TIME(ACCESS_TIME)) u_dport (
    .clk(clk), .rst_n(rst_n), .req(d_req),
    .accept(d_accept), .access(d_access), .ready(d_ready)
  );

  logic [ADDRSIZE-1:0] i_addr_q, d_addr_q;
  logic                d_we_q;
  logic [WIDTH-1:0]    d_wdata_q;
  logic [NB-1:0]       d_be_q, d_be_in;

`ifdef MEM_BYTE_WRITE_EN
  assign d_be_in = d_be;
`else
  assign d_be_in = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_we_q    <= 1'b0;
      d_wdata_q <= '0;
      d_be_q    <= '0;
    end else begin
      if (i_accept) i_addr_q <= i_addr;
      if (d_accept) begin
        d_addr_q  <= d_addr;
        d_we_q    <= d_we;
        d_wdata_q <= d_wdata;
        d_be_q    <= d_be_in;
      end
    end
  end

  // With zero wait states the access uses the live request, not the latched copy.
  logic [ADDRSIZE-1:0] i_addr_a, d_addr_a;
  logic                d_we_a;
  logic [WIDTH-1:0]    d_wdata_a;
  logic [NB-1:0]       d_be_a;

  assign i_addr_a  = ZW ? i_addr  : i_addr_q;
  assign d_addr_a  = ZW ? d_addr  : d_addr_q;
  assign d_we_a    = ZW ? d_we    : d_we_q;
  assign d_wdata_a = ZW ? d_wdata : d_wdata_q;
  assign d_be_a    = ZW ? d_be_in : d_be_q;

  always_ff @(posedge clk) begin
    if (d_access && d_we_a) begin
      for (int k = 0; k < NB; k++) begin
        if (d_be_a[k]) mem[d_addr_a][8*k +: 8] <= d_wdata_a[8*k +: 8];
      end
    end
  end

  // Read-first: a store and fetch on the same edge both see the pre-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (i_access) i_rdata <= mem[i_addr_a];
      if (d_access) d_rdata <= mem[d_addr_a];
    end
  end
endmodule

// File: tb/tb_harvard_wait_memory.sv
// Directed bench: three DUTs (ACCESS_TIME 0, 2, 3) share stimulus; each test checks one or all.
module tb_harvard_wait_memory;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic d_req = 1'b0;
  logic d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0] d_be = 4'hF;

  logic [2:0] i_rdy, d_rdy;
  logic [31:0] i_rd [3];
  logic [31:0] d_rd [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    harvard_wait_memory #(
      .ADDRSIZE(AW), .WIDTH(32), .ACCESS_TIME((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_rdy[g]), .i_rdata(i_rd[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef MEM_BYTE_WRITE_EN
      .d_be(d_be),
`endif
      .d_ready(d_rdy[g]), .d_rdata(d_rd[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single data transaction, long enough for the slowest DUT to finish.
  task automatic op(input logic we, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] be);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    tick();
    d_req = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (i_rdy[g] !== 1'b0 || d_rdy[g] !== 1'b0 || i_rd[g] !== 32'h0 || d_rd[g] !== 32'h0) begin
        errors++;
        $display("FAIL reset dut%0d: i_ready=%b d_ready=%b i_rdata=%h d_rdata=%h, want 0", g, i_rdy[g], d_rdy[g], i_rd[g], d_rd[g]);
      end
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_latency();
    logic [3:0] want = 4'b0100;
    op(1'b1, 6'd5, 32'h1234_5678, 4'hF);
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd5;
    for (int c = 0; c < 4; c++) begin
      tick();
      d_req = 1'b0;
      checks++;
      if (d_rdy[1] !== want[c]) begin
        errors++;
        $display("FAIL latency ready after E%0d: got %b want %b", c, d_rdy[1], want[c]);
      end
      if (c == 2) begin
        checks++;
        if (d_rd[1] !== 32'h1234_5678) begin
          errors++;
          $display("FAIL latency rdata: got %h want 12345678", d_rd[1]);
        end
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    op(1'b1, 6'd7, 32'h1111_0000, 4'hF);
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd7; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    tick();
    checks++;
    if (d_rdy[0] !== 1'b1 || d_rd[0] !== 32'h1111_0000) begin
      errors++;
      $display("FAIL b2b store: ready=%b rdata=%h want 1/11110000", d_rdy[0], d_rd[0]);
    end
    d_we = 1'b0;
    tick();
    checks++;
    if (d_rdy[0] !== 1'b1 || d_rd[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL b2b load: ready=%b rdata=%h want 1/deadbeef", d_rdy[0], d_rd[0]);
    end
    d_req = 1'b0;
    tick();
    checks++;
    if (d_rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle: ready=%b want 0", d_rdy[0]);
    end
    repeat (6) tick();
  endtask

  task automatic test_collision();
    op(1'b1, 6'd9, 32'h9999_9999, 4'hF);
    i_req = 1'b1; i_addr = 6'd9;
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd9; d_wdata = 32'hA5A5_A5A5; d_be = 4'hF;
    tick();
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) tick();
    checks++;
    if (i_rdy[1] !== 1'b1 || d_rdy[1] !== 1'b1 || i_rd[1] !== 32'h9999_9999) begin
      errors++;
      $display("FAIL collision: i_ready=%b d_ready=%b i_rdata=%h want 1/1/99999999", i_rdy[1], d_rdy[1], i_rd[1]);
    end
    repeat (4) tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (i_rd[g] !== 32'h9999_9999) begin
        errors++;
        $display("FAIL collision old dut%0d: got %h want 99999999", g, i_rd[g]);
      end
    end
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    repeat (6) tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (i_rd[g] !== 32'hA5A5_A5A5) begin
        errors++;
        $display("FAIL collision new dut%0d: got %h want a5a5a5a5", g, i_rd[g]);
      end
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] want;
    logic [31:0] want0;
`ifdef MEM_BYTE_WRITE_EN
    want  = 32'h0022_0044;
    want0 = 32'h0022_0044;
`else
    want  = 32'h1122_3344;
    want0 = 32'h55AA_55AA;
`endif
    op(1'b1, 6'd3, 32'h0000_0000, 4'hF);
    op(1'b1, 6'd3, 32'h1122_3344, 4'b0101);
    op(1'b0, 6'd3, 32'h0, 4'h0);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (d_rd[g] !== want) begin
        errors++;
        $display("FAIL byte_write dut%0d: got %h want %h", g, d_rd[g], want);
      end
    end
    // Empty strobe still completes; without strobes it is a full store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd3; d_wdata = 32'h55AA_55AA; d_be = 4'h0;
    tick();
    d_req = 1'b0;
    checks++;
    if (d_rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL byte_write zero-be ready: got %b want 1", d_rdy[0]);
    end
    repeat (6) tick();
    op(1'b0, 6'd3, 32'h0, 4'hF);
    checks++;
    if (d_rd[1] !== want0) begin
      errors++;
      $display("FAIL byte_write zero-be data: got %h want %h", d_rd[1], want0);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    op(1'b1, 6'd2, 32'h2222_2222, 4'hF);
    op(1'b0, 6'd2, 32'h0, 4'hF);
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd2; d_wdata = 32'h0000_0BAD; d_be = 4'hF;
    tick();
    d_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_rdy[2] !== 1'b0 || d_rd[2] !== 32'h0 || i_rd[2] !== 32'h0) begin
      errors++;
      $display("FAIL abort clear: d_ready=%b d_rdata=%h i_rdata=%h want 0", d_rdy[2], d_rd[2], i_rd[2]);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (d_rdy[2] === 1'b1 || d_rdy[1] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort ready: got %0d pulses want 0", pulses);
    end
    op(1'b0, 6'd2, 32'h0, 4'hF);
    checks++;
    if (d_rd[2] !== 32'h2222_2222 || d_rd[1] !== 32'h2222_2222) begin
      errors++;
      $display("FAIL abort mem: got %h/%h want 22222222", d_rd[2], d_rd[1]);
    end
  endtask

  task automatic test_throughput();
    int pulses = 0;
    for (int a = 16; a < 28; a++) op(1'b1, AW'(a), 32'h1000 + a, 4'hF);
    i_req = 1'b1; i_addr = 6'd16;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (i_rdy[1] === 1'b1) begin
        checks++;
        if (i_rd[1] !== 32'h1000 + 16 + 3 * pulses) begin
          errors++;
          $display("FAIL throughput data #%0d: got %h want %h", pulses, i_rd[1], 32'h1000 + 16 + 3 * pulses);
        end
        pulses++;
      end
      i_addr = AW'(17 + c);
    end
    i_req = 1'b0;
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL throughput count: got %0d want 4", pulses);
    end
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_back_to_back();
    test_collision();
    test_byte_write();
    test_reset_abort();
    test_throughput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
